// File: rtl/traffic_request_conditioner_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// traffic_pkg : types and constants shared by the 4-way traffic controller
//               and its request conditioner.
// Rev 1.0
// ---------------------------------------------------------------------------
package traffic_pkg;

  localparam int NUM_DIR = 4;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_RESET_LAST = 2'd3;

  typedef enum logic [1:0] {
    CTRL_ALL_RED = 2'd0,
    CTRL_GREEN   = 2'd1,
    CTRL_YELLOW  = 2'd2
  } ctrl_state_e;

  // Direction arithmetic wraps modulo NUM_DIR by construction of dir_t.
  function automatic dir_t dir_step(dir_t base, logic [2:0] offset);
    return base + offset[1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_request_conditioner_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// traffic_debounce : one detector channel - 2-flop synchroniser, debounce
//                    counter and rising-edge pulse of the debounced level.
// Rev 1.0
// ---------------------------------------------------------------------------
module traffic_debounce
  import traffic_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

  logic             sync1_q;
  logic             sync2_q;
  logic             db_q;
  logic             db_d;
  logic             db_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Compare before increment so the counter never passes CNT_LAST.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= async_i;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  assign rise_o = db_q & ~db_prev_q;

endmodule
`default_nettype wire

// File: rtl/traffic_request_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// traffic_request_conditioner : debounced, sticky per-direction requests
//                               plus a registered round-robin serve hint.
// Rev 1.0
// ---------------------------------------------------------------------------
module traffic_request_conditioner
  import traffic_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          CNT_W           = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_DIR-1:0] sensor_in,
  input  logic               serve_ack,
  input  dir_t               serve_dir,
  output logic [NUM_DIR-1:0] req_out,
  output logic               req_any,
  output dir_t               next_dir,
  output logic               next_valid
);

  logic [NUM_DIR-1:0] rise;
  logic [NUM_DIR-1:0] clr;
  logic [NUM_DIR-1:0] req_q;
  logic [NUM_DIR-1:0] req_d;
  logic               req_any_q;
  dir_t               last_q;
  dir_t               last_d;
  dir_t               arb_dir;
  logic               arb_valid;
  dir_t               cand;
  dir_t               next_dir_q;
  logic               next_valid_q;

  generate
    for (genvar i = 0; i < NUM_DIR; i++) begin : g_chan
      traffic_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .async_i (sensor_in[i]),
        .rise_o  (rise[i])
      );
    end
  endgenerate

  // Set has priority over clear so an arrival coinciding with an ack survives.
  always_comb begin
    clr = '0;
    if (serve_ack) begin
      clr[serve_dir] = 1'b1;
    end
    req_d  = (req_q & ~clr) | rise;
    last_d = serve_ack ? serve_dir : last_q;
  end

  // The last-served direction is visited last, preventing starvation.
  always_comb begin
    arb_dir   = dir_step(last_q, 3'd1);
    arb_valid = 1'b0;
    cand      = last_q;
    for (int k = 1; k <= NUM_DIR; k++) begin
      cand = dir_step(last_q, 3'(k));
      if (!arb_valid && req_q[cand]) begin
        arb_dir   = cand;
        arb_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q        <= '0;
      req_any_q    <= 1'b0;
      last_q       <= DIR_RESET_LAST;
      next_dir_q   <= 2'd0;
      next_valid_q <= 1'b0;
    end else begin
      req_q        <= req_d;
      req_any_q    <= |req_d;
      last_q       <= last_d;
      next_dir_q   <= arb_dir;
      next_valid_q <= arb_valid;
    end
  end

  assign req_out    = req_q;
  assign req_any    = req_any_q;
  assign next_dir   = next_dir_q;
  assign next_valid = next_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_request_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_traffic_request_conditioner : directed scenarios with DEBOUNCE_CYCLES=4.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_traffic_request_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sensor_in = 4'b0000;
  logic       serve_ack = 1'b0;
  logic [1:0] serve_dir = 2'd0;
  logic [3:0] req_out;
  logic       req_any;
  logic [1:0] next_dir;
  logic       next_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  traffic_request_conditioner #(
    .DEBOUNCE_CYCLES (16'd4),
    .CNT_W           (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sensor_in  (sensor_in),
    .serve_ack  (serve_ack),
    .serve_dir  (serve_dir),
    .req_out    (req_out),
    .req_any    (req_any),
    .next_dir   (next_dir),
    .next_valid (next_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    sensor_in = 4'b0000;
    serve_ack = 1'b0;
    serve_dir = 2'd0;
    reset     = 1'b1;
    ticks(2);
    reset     = 1'b0;
  endtask

  task automatic ack(input logic [1:0] d);
    serve_ack = 1'b1;
    serve_dir = d;
    tick();
    serve_ack = 1'b0;
    serve_dir = 2'd0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      total++;
      if ({req_out, req_any, next_valid, next_dir} !== 8'b0) begin
        bad++;
        $display("FAIL reset_idle cycle=%0d got req=%b any=%b nv=%b nd=%0d exp all 0",
                 c, req_out, req_any, next_valid, next_dir);
      end
      tick();
    end
  endtask

  task automatic test_single_request();
    do_reset();
    sensor_in = 4'b0010;
    ticks(6);
    total++;
    if (req_out !== 4'b0000) begin
      bad++; $display("FAIL single_early got=%b exp=0000", req_out);
    end
    tick();
    total++;
    if ({req_any, req_out} !== 5'b1_0010) begin
      bad++; $display("FAIL single_req got any=%b req=%b exp any=1 req=0010", req_any, req_out);
    end
    total++;
    if (next_valid !== 1'b0) begin
      bad++; $display("FAIL single_nv_early got=%b exp=0", next_valid);
    end
    tick();
    total++;
    if ({next_valid, next_dir} !== 3'b1_01) begin
      bad++; $display("FAIL single_next got nv=%b nd=%0d exp nv=1 nd=1", next_valid, next_dir);
    end
    ack(2'd1);
    total++;
    if ({req_any, req_out} !== 5'b0_0000 || next_valid !== 1'b1) begin
      bad++; $display("FAIL single_clear got any=%b req=%b nv=%b exp any=0 req=0000 nv=1",
                      req_any, req_out, next_valid);
    end
    tick();
    total++;
    if ({next_valid, next_dir} !== 3'b0_10) begin
      bad++; $display("FAIL single_next_clear got nv=%b nd=%0d exp nv=0 nd=2", next_valid, next_dir);
    end
    ticks(10);
    total++;
    if (req_out !== 4'b0000) begin
      bad++; $display("FAIL single_no_rereq got=%b exp=0000", req_out);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int r = 0; r < 5; r++) begin
      sensor_in = 4'b0100;
      for (int c = 0; c < 3; c++) begin
        tick();
        total++;
        if (req_out !== 4'b0000) begin
          bad++; $display("FAIL glitch_high r=%0d c=%0d got=%b exp=0000", r, c, req_out);
        end
      end
      sensor_in = 4'b0000;
      for (int c = 0; c < 2; c++) begin
        tick();
        total++;
        if (req_out !== 4'b0000) begin
          bad++; $display("FAIL glitch_low r=%0d c=%0d got=%b exp=0000", r, c, req_out);
        end
      end
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (req_out !== 4'b0000) begin
        bad++; $display("FAIL glitch_tail c=%0d got=%b exp=0000", c, req_out);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    sensor_in = 4'b1010;
    ticks(9);
    total++;
    if (req_out !== 4'b1010) begin
      bad++; $display("FAIL rr_setup got=%b exp=1010", req_out);
    end
    ack(2'd0);
    tick();
    total++;
    if (req_out !== 4'b1010 || {next_valid, next_dir} !== 3'b1_01) begin
      bad++; $display("FAIL rr_idle_ack0 got req=%b nv=%b nd=%0d exp req=1010 nv=1 nd=1",
                      req_out, next_valid, next_dir);
    end
    sensor_in = 4'b1011;
    ticks(9);
    total++;
    if (req_out !== 4'b1011 || {next_valid, next_dir} !== 3'b1_01) begin
      bad++; $display("FAIL rr_start got req=%b nv=%b nd=%0d exp req=1011 nv=1 nd=1",
                      req_out, next_valid, next_dir);
    end
    ack(2'd1);
    tick();
    total++;
    if (req_out !== 4'b1001 || {next_valid, next_dir} !== 3'b1_11) begin
      bad++; $display("FAIL rr_after_ack1 got req=%b nv=%b nd=%0d exp req=1001 nv=1 nd=3",
                      req_out, next_valid, next_dir);
    end
    ack(2'd3);
    tick();
    total++;
    if (req_out !== 4'b0001 || {next_valid, next_dir} !== 3'b1_00) begin
      bad++; $display("FAIL rr_after_ack3 got req=%b nv=%b nd=%0d exp req=0001 nv=1 nd=0",
                      req_out, next_valid, next_dir);
    end
    ack(2'd0);
    tick();
    total++;
    if (req_out !== 4'b0000 || {next_valid, next_dir} !== 3'b0_01) begin
      bad++; $display("FAIL rr_after_ack0 got req=%b nv=%b nd=%0d exp req=0000 nv=0 nd=1",
                      req_out, next_valid, next_dir);
    end
  endtask

  task automatic test_collision();
    do_reset();
    sensor_in = 4'b0101;
    ticks(6);
    serve_ack = 1'b1;
    serve_dir = 2'd2;
    tick();
    serve_ack = 1'b0;
    serve_dir = 2'd0;
    total++;
    if (req_out !== 4'b0101) begin
      bad++; $display("FAIL coll_set_wins got=%b exp=0101", req_out);
    end
    tick();
    total++;
    if ({next_valid, next_dir} !== 3'b1_00) begin
      bad++; $display("FAIL coll_next got nv=%b nd=%0d exp nv=1 nd=0", next_valid, next_dir);
    end
    ack(2'd1);
    tick();
    total++;
    if (req_out !== 4'b0101 || {next_valid, next_dir} !== 3'b1_10) begin
      bad++; $display("FAIL coll_idle_ack1 got req=%b nv=%b nd=%0d exp req=0101 nv=1 nd=2",
                      req_out, next_valid, next_dir);
    end
    ack(2'd3);
    total++;
    if (req_out !== 4'b0101) begin
      bad++; $display("FAIL coll_idle_ack3_req got=%b exp=0101", req_out);
    end
    tick();
    total++;
    if ({next_valid, next_dir} !== 3'b1_00) begin
      bad++; $display("FAIL coll_idle_ack3_next got nv=%b nd=%0d exp nv=1 nd=0", next_valid, next_dir);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    sensor_in = 4'b0101;
    ticks(9);
    total++;
    if (req_out !== 4'b0101) begin
      bad++; $display("FAIL areset_setup got=%b exp=0101", req_out);
    end
    sensor_in = 4'b0111;
    ticks(4);
    reset = 1'b1;
    #2;
    total++;
    if ({req_out, req_any, next_valid, next_dir} !== 8'b0) begin
      bad++; $display("FAIL areset_immediate got req=%b any=%b nv=%b nd=%0d exp all 0",
                      req_out, req_any, next_valid, next_dir);
    end
    #1;
    reset = 1'b0;
    ticks(6);
    total++;
    if (req_out !== 4'b0000) begin
      bad++; $display("FAIL areset_relatch_early got=%b exp=0000", req_out);
    end
    tick();
    total++;
    if (req_out !== 4'b0111) begin
      bad++; $display("FAIL areset_relatch got=%b exp=0111", req_out);
    end
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_glitch();
    test_round_robin();
    test_collision();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
